store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Committed-store write buffer between the ROB commit stage and the memory controller's byte-wide RAM port.
- Accepts committed SB/SH/SW from the ROB via the mc_st_ena/mc_st_done handshake and acknowledges as soon as the store is queued.
- Drains stores in order, one byte per granted cycle.
- Flags younger loads that overlap a pending store.

Parameters:
- SB_BIT, 3: log2 of buffer depth (depth 8).
- ADDR_W, 32: address width.
- DATA_W, 32: store data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-low (asserted when 0)
- rdy  in  1  global ready; 0 freezes all state
- st_ena  in  1  ROB store request (level, held until st_done)
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data, little-endian
- st_len  in  4  bytes-1: 0=SB, 1=SH, 3=SW
- st_done  out  1  one-cycle acknowledge: store queued
- mem_req  out  1  byte write request to memctrl
- mem_a  out  ADDR_W  byte address
- mem_dout  out  8  byte data
- mem_gnt  in  1  memctrl grant for this cycle
- io_buffer_full  in  1  UART buffer full
- ld_chk_addr  in  ADDR_W  pending load address
- ld_chk_len  in  4  pending load bytes-1
- ld_conflict  out  1  combinational: load overlaps a queued store
- sb_empty  out  1  no valid entries
- sb_full  out  1  count == depth

Behaviour:
- Reset (rst==0 at posedge): head=tail=0, count=0, byte_cnt=0, state=IDLE, st_done=0, all entry valid bits 0. Outputs after reset: mem_req=0, mem_a=0, mem_dout=0, sb_empty=1, sb_full=0. Reset mid-drain discards every queued store, including one partially written.
- rdy==0: no register changes; mem_req forced 0; st_done holds its value.
- Enqueue:
  - Occurs at a posedge when st_ena && !st_done && count<depth. The count is checked before the same-cycle pop, so there is no full-bypass.
  - Writes {addr, data, len} at tail; tail wraps depth-1 -> 0; st_done<=1 for exactly one cycle.
  - No enqueue while st_done==1: the ROB drops st_ena on the edge it samples st_done, so this blocks a duplicate enqueue.
  - Latency: st_ena high with space available -> st_done high in the next cycle.
  - Full: st_done stays 0 and the request waits.
- Drain FSM, states IDLE and WRITE:
  - IDLE -> WRITE when count>0; byte_cnt=0.
  - WRITE: mem_req=1, mem_a=addr[head]+byte_cnt (32-bit add, no wrap handling), mem_dout=data[head][8*byte_cnt+:8].
  - An IO entry (addr[17:16]==2'b11) with io_buffer_full==1 deasserts mem_req and stalls.
  - A byte completes at a posedge with mem_req && mem_gnt; byte_cnt++.
  - After byte byte_cnt==len completes: pop head (head wraps), count--, byte_cnt=0. Go to IDLE if count becomes 0, else stay in WRITE for the next entry with no bubble.
  - Simultaneous enqueue and pop: count unchanged.
  - Data is visible to memctrl in the same cycle as mem_req.
- Entry lifetime: queued stores are architecturally committed, so ROB rollback does not flush the buffer. There is no flush input.
- ld_conflict:
  - 1 if any valid entry satisfies e.addr <= ld_hi && ld_addr <= e.addr+e.len, with ld_hi = ld_chk_addr+ld_chk_len. Unsigned 32-bit compares.
  - Also 1 if the load is IO and any IO entry is valid.
  - Includes the head entry being drained; it does not include an st_ena not yet enqueued.
- Count register is SB_BIT+1 bits wide. sb_full and sb_empty are derived from the registered count.

Decomposition:
- Shared utils.v gains:
  - SB_IDX_LN (=3) and SB_IDX_TP.
  - IO_ADDR_HI (2'b11), with an IO-address test macro on addr[17:16].
  - ST_LEN_B/H/W constants (0/1/3), also used by the ROB.
- One sub-module: sb_range_cmp. It is a per-entry combinational overlap check (addr, len, valid vs load range), instantiated depth times and OR-reduced.

Test Plan:
- SW addr 0x1000 data 0xAABBCCDD, mem_gnt=1: st_done one cycle after st_ena. Bytes DD,CC,BB,AA at 0x1000-0x1003 on 4 consecutive cycles; then sb_empty=1.
- Fill 8 SBs without grant: sb_full=1 and a 9th st_ena gets no st_done. One drain pop lets it enqueue; tail wraps to 0 and order is preserved.
- st_ena held one extra cycle after st_done: exactly one entry enqueued (count==1).
- SB to 0x30000 with io_buffer_full=1 for 5 cycles: mem_req=0 throughout; byte is written the cycle after full drops.
- Queue SH addr 0x2002, then check LW at 0x2000: ld_conflict=1. LW at 0x2004: ld_conflict=0. After the SH drains, LW at 0x2000 gives 0.
- rst=0 mid-SW, after 2 bytes are written: next cycle mem_req=0, sb_empty=1, st_done=0, and no further bytes are written.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared store-buffer types, IO address test and store length codes
package store_buffer_pkg;

    localparam int SB_IDX_LN = 3;
    typedef logic [SB_IDX_LN-1:0] sb_idx_t;
    localparam int SB_IDX_TP = 1 << SB_IDX_LN;

    // addr[17:16] == 2'b11 selects the IO region (UART and friends)
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // st_len encodes bytes-1; shared with the ROB
    localparam logic [3:0] ST_LEN_B = 4'd0;
    localparam logic [3:0] ST_LEN_H = 4'd1;
    localparam logic [3:0] ST_LEN_W = 4'd3;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_WRITE = 1'b1
    } sb_state_e;

    function automatic logic is_io_hi(input logic [1:0] addr_hi);
        return addr_hi == IO_ADDR_HI;
    endfunction

endpackage

// File: rtl/store_buffer_range_cmp.sv
// rtl/store_buffer_range_cmp.sv - per-entry overlap check of a queued store against a load range
module sb_range_cmp
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              e_valid,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [3:0]        e_len,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] ld_hi,
    input  logic              ld_is_io,
    output logic              hit
);

    logic [ADDR_W-1:0] e_hi;
    logic              overlap;
    logic              io_hit;

    always_comb begin
        e_hi    = e_addr + ADDR_W'(e_len);
        overlap = (e_addr <= ld_hi) && (ld_addr <= e_hi);
        // IO loads must not bypass any pending IO store, whatever the address
        io_hit  = ld_is_io && is_io_hi(e_addr[17:16]);
        hit     = e_valid && (overlap || io_hit);
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - committed-store queue draining one byte per granted cycle to memctrl
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int SB_BIT = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              st_ena,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [3:0]        st_len,
    output logic              st_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    input  logic              mem_gnt,
    input  logic              io_buffer_full,
    input  logic [ADDR_W-1:0] ld_chk_addr,
    input  logic [3:0]        ld_chk_len,
    output logic              ld_conflict,
    output logic              sb_empty,
    output logic              sb_full
);

    localparam int DEPTH = 1 << SB_BIT;
    localparam logic [SB_BIT:0] CNT_DEPTH = (SB_BIT + 1)'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [3:0]        len_q  [DEPTH];
    logic [3:0]        len_d  [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [SB_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [SB_BIT:0]   count_q, count_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    sb_state_e         state_q, state_d;
    logic              st_done_q, st_done_d;

    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic [3:0]        h_len;
    logic              enq, pop, byte_fire, last_byte;
    logic [ADDR_W-1:0] ld_hi;
    logic              ld_is_io;
    logic [DEPTH-1:0]  hits;

    always_comb begin
        h_addr    = addr_q[head_q];
        h_data    = data_q[head_q];
        h_len     = len_q[head_q];
        // count is checked before the same-cycle pop: no full-bypass
        enq       = rdy && st_ena && !st_done_q && (count_q < CNT_DEPTH);
        mem_req   = rdy && (state_q == SB_WRITE) &&
                    !(is_io_hi(h_addr[17:16]) && io_buffer_full);
        mem_a     = (state_q == SB_WRITE) ? h_addr + ADDR_W'(byte_cnt_q) : '0;
        mem_dout  = (state_q == SB_WRITE) ? h_data[8*byte_cnt_q +: 8] : '0;
        byte_fire = mem_req && mem_gnt;
        last_byte = ({2'b00, byte_cnt_q} == h_len);
        pop       = byte_fire && last_byte;
        st_done   = st_done_q;
        sb_empty  = (count_q == '0);
        sb_full   = (count_q == CNT_DEPTH);
        ld_hi     = ld_chk_addr + ADDR_W'(ld_chk_len);
        ld_is_io  = is_io_hi(ld_chk_addr[17:16]);
        ld_conflict = |hits;
    end

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        len_d      = len_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        byte_cnt_d = byte_cnt_q;
        state_d    = state_q;
        st_done_d  = st_done_q;
        if (rdy) begin
            st_done_d = enq;
            if (enq) begin
                addr_d[tail_q]  = st_addr;
                data_d[tail_q]  = st_data;
                len_d[tail_q]   = st_len;
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + SB_BIT'(1);
            end
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + SB_BIT'(1);
            end
            count_d = count_q + (SB_BIT + 1)'(enq) - (SB_BIT + 1)'(pop);
            case (state_q)
                SB_IDLE: begin
                    if (count_q != '0) begin
                        state_d    = SB_WRITE;
                        byte_cnt_d = '0;
                    end
                end
                SB_WRITE: begin
                    if (byte_fire) begin
                        if (last_byte) begin
                            // next entry starts without a bubble unless the queue ran dry
                            byte_cnt_d = '0;
                            if (count_d == '0) state_d = SB_IDLE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = SB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            state_q    <= SB_IDLE;
            st_done_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            state_q    <= state_d;
            st_done_q  <= st_done_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        sb_range_cmp #(.ADDR_W(ADDR_W)) u_cmp (
            .e_valid (valid_q[i]),
            .e_addr  (addr_q[i]),
            .e_len   (len_q[i]),
            .ld_addr (ld_chk_addr),
            .ld_hi   (ld_hi),
            .ld_is_io(ld_is_io),
            .hit     (hits[i])
        );
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized bench for store_buffer with a queue-level reference model
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        st_ena = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_len = '0;
    logic        st_done;
    logic        mem_req;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_gnt = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [31:0] ld_chk_addr = '0;
    logic [3:0]  ld_chk_len = '0;
    logic        ld_conflict;
    logic        sb_empty;
    logic        sb_full;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  l;
        int          done;
    } st_t;

    st_t         pend[$];
    logic [39:0] wr_log[$];
    logic [39:0] exp_log[$];

    store_buffer #(.SB_BIT(3), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .st_ena(st_ena), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
        .mem_req(mem_req), .mem_a(mem_a), .mem_dout(mem_dout), .mem_gnt(mem_gnt),
        .io_buffer_full(io_buffer_full),
        .ld_chk_addr(ld_chk_addr), .ld_chk_len(ld_chk_len), .ld_conflict(ld_conflict),
        .sb_empty(sb_empty), .sb_full(sb_full)
    );

    always #5 clk = ~clk;

    // every byte the memory controller actually accepts
    always @(posedge clk) begin
        if (rst && rdy && mem_req && mem_gnt) wr_log.push_back({mem_a, mem_dout});
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model_conflict(input logic [31:0] la, input logic [3:0] ll);
        logic [31:0] hi;
        hi = la + {28'd0, ll};
        foreach (pend[i]) begin
            if (pend[i].a <= hi && la <= pend[i].a + {28'd0, pend[i].l}) return 1'b1;
            if (la[17:16] == 2'b11 && pend[i].a[17:16] == 2'b11) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] pick_len();
        case ($urandom % 3)
            0: return ST_LEN_B;
            1: return ST_LEN_H;
            default: return ST_LEN_W;
        endcase
    endfunction

    // drives one store and waits for its acknowledge; returns at the negedge where st_done is seen
    task automatic enqueue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] l);
        logic ok;
        ok = 1'b0;
        st_ena = 1'b1; st_addr = a; st_data = d; st_len = l;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (st_done) begin ok = 1'b1; break; end
        end
        st_ena = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL enqueue_ack addr=%h got=no st_done exp=st_done within 40 cycles", a);
        end else begin
            for (int b = 0; b <= int'(l); b++) exp_log.push_back({a + 32'(b), d[8*b +: 8]});
        end
    endtask

    task automatic wait_empty(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb_empty) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_drain got=sb_empty 0 exp=1 within 100 cycles", name); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checks += 7;
        if (mem_req !== 1'b0)      begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        if (mem_a !== 32'h0)       begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        if (mem_dout !== 8'h0)     begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        if (sb_empty !== 1'b1)     begin failures++; $display("FAIL reset_sb_empty got=%b exp=1", sb_empty); end
        if (sb_full !== 1'b0)      begin failures++; $display("FAIL reset_sb_full got=%b exp=0", sb_full); end
        if (st_done !== 1'b0)      begin failures++; $display("FAIL reset_st_done got=%b exp=0", st_done); end
        if (ld_conflict !== 1'b0)  begin failures++; $display("FAIL reset_ld_conflict got=%b exp=0", ld_conflict); end
    endtask

    task automatic test_sw_drain();
        logic [31:0] d;
        d = 32'hAABBCCDD;
        mem_gnt = 1'b1;
        st_ena = 1'b1; st_addr = 32'h1000; st_data = d; st_len = ST_LEN_W;
        @(negedge clk);
        checks++;
        if (st_done !== 1'b1) begin failures++; $display("FAIL sw_latency got=%b exp=1", st_done); end
        st_ena = 1'b0;
        for (int i = 0; i < 5 && !mem_req; i++) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_a !== 32'h1000 + 32'(b) || mem_dout !== d[8*b +: 8]) begin
                failures++;
                $display("FAIL sw_byte%0d got=req %b a %h d %h exp=req 1 a %h d %h",
                         b, mem_req, mem_a, mem_dout, 32'h1000 + 32'(b), d[8*b +: 8]);
            end
            @(negedge clk);
        end
        checks++;
        if (sb_empty !== 1'b1) begin failures++; $display("FAIL sw_empty got=%b exp=1", sb_empty); end
    endtask

    task automatic test_fill_full();
        logic ok;
        wr_log.delete(); exp_log.delete();
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) enqueue(32'h5000 + 32'(i * 16), $urandom, ST_LEN_B);
        checks++;
        if (sb_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", sb_full); end
        st_ena = 1'b1; st_addr = 32'h5100; st_data = 32'h0000_00E9; st_len = ST_LEN_B;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (st_done !== 1'b0) begin failures++; $display("FAIL full_no_ack cycle=%0d got=%b exp=0", i, st_done); end
        end
        mem_gnt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st_done) begin ok = 1'b1; break; end
        end
        st_ena = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL full_ninth_ack got=no st_done exp=st_done after pop"); end
        else exp_log.push_back({32'h5100, 8'hE9});
        wait_empty("full");
        checks++;
        if (wr_log.size() != exp_log.size()) begin
            failures++; $display("FAIL full_byte_count got=%0d exp=%0d", wr_log.size(), exp_log.size());
        end else begin
            foreach (exp_log[i]) begin
                checks++;
                if (wr_log[i] !== exp_log[i]) begin
                    failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, wr_log[i], exp_log[i]);
                end
            end
        end
    endtask

    task automatic test_hold_ena();
        logic ok;
        wr_log.delete(); exp_log.delete();
        mem_gnt = 1'b0;
        st_ena = 1'b1; st_addr = 32'h6000; st_data = 32'h0000_1234; st_len = ST_LEN_H;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_done) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        st_ena = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL hold_ack got=no st_done exp=st_done"); end
        mem_gnt = 1'b1;
        wait_empty("hold");
        checks++;
        if (wr_log.size() != 2) begin failures++; $display("FAIL hold_single_entry got=%0d bytes exp=2", wr_log.size()); end
    endtask

    task automatic test_io_stall();
        wr_log.delete(); exp_log.delete();
        mem_gnt = 1'b1; io_buffer_full = 1'b1;
        enqueue(32'h0003_0000, 32'h0000_005A, ST_LEN_B);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ld_chk_addr = 32'h0003_0100; ld_chk_len = ST_LEN_W; #1;
                checks++;
                if (ld_conflict !== 1'b1) begin failures++; $display("FAIL io_load_conflict got=%b exp=1", ld_conflict); end
            end
            checks++;
            if (mem_req !== 1'b0) begin failures++; $display("FAIL io_stall cycle=%0d got=%b exp=0", i, mem_req); end
            @(negedge clk);
        end
        io_buffer_full = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b1 || mem_a !== 32'h0003_0000) begin
            failures++; $display("FAIL io_release got=req %b a %h exp=req 1 a 00030000", mem_req, mem_a);
        end
        @(negedge clk);
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {32'h0003_0000, 8'h5A}) begin
            failures++; $display("FAIL io_write got=%0d bytes exp=1 byte 5a at 00030000", wr_log.size());
        end
        ld_chk_addr = 32'h0; ld_chk_len = 4'd0;
    endtask

    task automatic test_ld_conflict();
        logic [31:0] la [5];
        logic [3:0]  ll [5];
        logic        ex [5];
        la = '{32'h2000, 32'h2004, 32'h2003, 32'h2001, 32'h0003_0000};
        ll = '{ST_LEN_W, ST_LEN_W, ST_LEN_B, ST_LEN_B, ST_LEN_W};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        mem_gnt = 1'b0;
        enqueue(32'h2002, 32'h0000_BEEF, ST_LEN_H);
        for (int i = 0; i < 5; i++) begin
            ld_chk_addr = la[i]; ld_chk_len = ll[i]; #1;
            checks++;
            if (ld_conflict !== ex[i]) begin
                failures++; $display("FAIL ld_conflict addr=%h len=%0d got=%b exp=%b", la[i], ll[i], ld_conflict, ex[i]);
            end
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        wait_empty("ld");
        ld_chk_addr = 32'h2000; ld_chk_len = ST_LEN_W; #1;
        checks++;
        if (ld_conflict !== 1'b0) begin failures++; $display("FAIL ld_after_drain got=%b exp=0", ld_conflict); end
        ld_chk_addr = 32'h0; ld_chk_len = 4'd0;
    endtask

    task automatic test_reset_mid_drain();
        wr_log.delete(); exp_log.delete();
        mem_gnt = 1'b1;
        enqueue(32'h4000, 32'h1122_3344, ST_LEN_W);
        for (int i = 0; i < 5 && !mem_req; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (mem_req !== 1'b0)  begin failures++; $display("FAIL midrst_mem_req got=%b exp=0", mem_req); end
        if (sb_empty !== 1'b1) begin failures++; $display("FAIL midrst_sb_empty got=%b exp=1", sb_empty); end
        if (st_done !== 1'b0)  begin failures++; $display("FAIL midrst_st_done got=%b exp=0", st_done); end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_log.size() != 2 || wr_log[0] !== {32'h4000, 8'h44} || wr_log[1] !== {32'h4001, 8'h33}) begin
            failures++; $display("FAIL midrst_bytes got=%0d bytes exp=2 bytes 44@4000 33@4001", wr_log.size());
        end
    endtask

    task automatic test_random();
        st_t         s, h;
        logic        exp_done, enq, fire, exp_c, drain, stalled;
        logic [31:0] base;
        pend.delete();
        @(negedge clk);
        rst = 1'b0; st_ena = 1'b0; rdy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        exp_done = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            drain = (cyc >= 600);
            if (drain && pend.size() == 0 && !st_ena) break;
            checks += 3;
            if (sb_empty !== (pend.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, sb_empty, pend.size() == 0); end
            if (sb_full !== (pend.size() == 8))  begin failures++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, sb_full, pend.size() == 8); end
            if (st_done !== exp_done)            begin failures++; $display("FAIL rnd_st_done cyc=%0d got=%b exp=%b", cyc, st_done, exp_done); end
            if (drain) begin
                rdy = 1'b1; mem_gnt = 1'b1; io_buffer_full = 1'b0;
            end else begin
                rdy = ($urandom % 8) != 0;
                mem_gnt = ($urandom % 3) != 0;
                io_buffer_full = ($urandom % 4) == 0;
            end
            if (st_ena && exp_done) begin
                st_ena = 1'b0;
            end else if (!st_ena && !drain && ($urandom % 2) == 0) begin
                base = (($urandom % 4) == 0) ? 32'h0003_0000 : 32'h0000_1000;
                st_ena = 1'b1; st_addr = base + $urandom_range(0, 31);
                st_data = $urandom; st_len = pick_len();
            end
            base = (($urandom % 4) == 0) ? 32'h0003_0000 : 32'h0000_1000;
            ld_chk_addr = base + $urandom_range(0, 35); ld_chk_len = pick_len();
            #1;
            exp_c = model_conflict(ld_chk_addr, ld_chk_len);
            checks++;
            if (ld_conflict !== exp_c) begin failures++; $display("FAIL rnd_ld_conflict cyc=%0d addr=%h got=%b exp=%b", cyc, ld_chk_addr, ld_conflict, exp_c); end
            if (!rdy) begin
                checks++;
                if (mem_req !== 1'b0) begin failures++; $display("FAIL rnd_frozen_req cyc=%0d got=%b exp=0", cyc, mem_req); end
            end
            if (mem_req) begin
                checks++;
                if (pend.size() == 0) begin
                    failures++; $display("FAIL rnd_req_empty cyc=%0d got=mem_req 1 exp=0", cyc);
                end else begin
                    h = pend[0];
                    stalled = (h.a[17:16] == 2'b11) && io_buffer_full;
                    if (mem_a !== h.a + 32'(h.done) || mem_dout !== h.d[8*h.done +: 8] || stalled) begin
                        failures++;
                        $display("FAIL rnd_byte cyc=%0d got=a %h d %h exp=a %h d %h io_stalled %b",
                                 cyc, mem_a, mem_dout, h.a + 32'(h.done), h.d[8*h.done +: 8], stalled);
                    end
                end
            end
            fire = rdy && mem_req && mem_gnt && pend.size() > 0;
            enq  = rdy && st_ena && !exp_done && pend.size() < 8;
            if (rdy) exp_done = enq;
            if (fire) begin
                h = pend[0];
                if (h.done == int'(h.l)) void'(pend.pop_front());
                else begin h.done++; pend[0] = h; end
            end
            if (enq) begin
                s.a = st_addr; s.d = st_data; s.l = st_len; s.done = 0;
                pend.push_back(s);
            end
            @(negedge clk);
        end
        checks++;
        if (pend.size() != 0 || sb_empty !== 1'b1) begin
            failures++; $display("FAIL rnd_final_drain got=model %0d entries sb_empty %b exp=0 entries sb_empty 1", pend.size(), sb_empty);
        end
    endtask

    initial begin
        test_reset();
        test_sw_drain();
        test_fill_full();
        test_hold_ena();
        test_io_stall();
        test_ld_conflict();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
